or_32: RTL and testbench

Registered 32-bit bitwise-OR unit for the datapath logic stage. Takes two operand words, produces `res = A | B` one clock after acceptance, and flags an all-zero result. A valid/ready handshake on both sides lets it sit between pipeline stages that can stall.

---
 rtl/or_32_pkg.sv | 12 +
 rtl/or_32_if.sv | 44 ++++
 rtl/or_32_slice.sv | 10 +
 rtl/or_32.sv | 55 +++++
 tb/tb_or_32.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/or_32_pkg.sv
// Shared definitions for the registered bitwise-OR unit: default width and
// the values the output register takes under reset.
package or_32_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Reset image of the output register: result cleared, zero flag set so
    // the pair stays self-consistent (0 | 0 is all-zero).
    localparam logic [DEFAULT_WIDTH-1:0] RES_RST  = '0;
    localparam logic                     ZERO_RST = 1'b1;

endpackage : or_32_pkg

// File: rtl/or_32_if.sv
// Valid/ready bus for the OR unit: operand side (in_*, A, B) and result side
// (out_*, res, zero). The master drives operands and consumes results; the
// slave is the OR unit itself.
interface or_32_if
    import or_32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             zero;

    modport master (
        output in_valid,
        output A,
        output B,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  res,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  out_ready,
        output in_ready,
        output out_valid,
        output res,
        output zero
    );

endinterface : or_32_if

// File: rtl/or_32_slice.sv
// One-bit OR cell, purely combinational. The top replicates it per bit.
module or_32_slice (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a | b;

endmodule : or_32_slice

// File: rtl/or_32.sv
// Registered WIDTH-bit bitwise OR with an all-zero flag and valid/ready
// handshakes on both sides. One-cycle latency, full throughput when the
// consumer is always ready. The only combinational path is
// out_valid/out_ready -> in_ready; operands reach res/zero only via flops.
module or_32
    import or_32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    or_32_if.slave bus
);

    logic [WIDTH-1:0] or_y;
    logic             or_zero;
    logic             accept;
    logic             drain;

    // Bit-parallel OR: no carries, so each bit is an independent cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        or_32_slice u_slice (
            .a (bus.A[i]),
            .b (bus.B[i]),
            .y (or_y[i])
        );
    end

    assign or_zero = ~|or_y;

    // A new pair may enter whenever the output register is empty or is being
    // emptied this same cycle; that overlap is what gives full throughput.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = bus.out_valid && bus.out_ready;

    // Output register: load on accept, clear valid on a drain with no refill,
    // otherwise hold (which covers both the stall case and the idle case).
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking (<=) so every flop samples
        // pre-edge values and the result never depends on statement order.
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.res       <= WIDTH'(RES_RST);
            bus.zero      <= ZERO_RST;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.res       <= or_y;
            bus.zero      <= or_zero;
        end else if (drain) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule : or_32

// File: tb/tb_or_32.sv
// Scoreboard bench for or_32: the driver pushes a hand-computed expected
// result for every accepted pair; an independent monitor pops and compares
// whenever the unit hands a result over (out_valid && out_ready).
module tb_or_32;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    logic clk;
    logic rst;

    or_32_if #(.WIDTH(32)) bus ();

    or_32 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Present one pair (with its hand-computed OR) and hold it until it is
    // accepted; returns just after the accepting edge with in_valid still set
    // so consecutive calls stream with no gap.
    task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] req);
        int n;
        n = 0;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
        end else begin
            exp_q.push_back('{name: name, res: req, zero: (req == 32'd0)});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every result handed to the consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_res"}, bus.res, e.res);
                    check({e.name, "_zero"}, {31'd0, bus.zero}, {31'd0, e.zero});
                end
            end
        end
    end

    logic [31:0] stream_a   [8] = '{32'h1111_1111, 32'h8000_0000, 32'hA5A5_A5A5, 32'h0F0F_0F0F,
                                    32'h0000_0000, 32'h1234_0000, 32'hDEAD_0000, 32'h0101_0101};
    logic [31:0] stream_b   [8] = '{32'h2222_2222, 32'h0000_0001, 32'h5A5A_5A5A, 32'h0F0F_0F0F,
                                    32'h0000_0000, 32'h0000_5678, 32'h0000_BEEF, 32'h1010_1010};
    logic [31:0] stream_req [8] = '{32'h3333_3333, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0F0F_0F0F,
                                    32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1111_1111};

    initial begin
        int n;

        // Reset with a valid pair on the inputs: nothing may be accepted.
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.A         = 32'hFFFF_FFFF;
        bus.B         = 32'hFFFF_FFFF;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_edge1_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_res",       bus.res, 32'd0);
        check("rst_zero",      {31'd0, bus.zero}, 32'd1);
        check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        // Basic OR and the extremes.
        send("basic", 32'h0000_FFFF, 32'h00FF_00FF, 32'h00FF_FFFF);
        check("basic_out_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        send("all_zero", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        send("all_ones", 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: result must hold and inputs must be ignored.
        bus.out_ready = 1'b0;
        send("bp", 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        for (int i = 0; i < 3; i++) begin
            bus.A        = 32'h1357_9BDF + 32'(i);
            bus.B        = 32'h0000_0000;
            bus.in_valid = 1'b1;
            @(negedge clk);
            check("bp_hold_res",       bus.res, 32'hF0F0_0F0F);
            check("bp_hold_in_ready",  {31'd0, bus.in_ready}, 32'd0);
            check("bp_hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_drained_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Streaming: back-to-back pairs, no bubbles on the output.
        for (int i = 0; i < 8; i++) begin
            send($sformatf("stream%0d", i), stream_a[i], stream_b[i], stream_req[i]);
            check($sformatf("stream%0d_no_bubble", i), {31'd0, bus.out_valid}, 32'd1);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a result is stalled: the result is discarded.
        bus.out_ready = 1'b0;
        send("midrst", 32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_stalled", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_res",       bus.res, 32'd0);
        check("midrst_zero",      {31'd0, bus.zero}, 32'd1);
        rst           = 1'b0;
        bus.out_ready = 1'b1;

        // Everything issued must have been delivered.
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_empty", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_or_32
